// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues one-cycle-latency imem reads and buffers
// returned {instr, pc} pairs in a DEPTH-entry queue presented to decode.
module fetch_queue #(
    parameter int               BITS       = 32,
    parameter int               DEPTH      = 4,
    parameter logic [BITS-1:0]  RESET_ADDR = '0,
    parameter int               CW         = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_,
    output logic            imem_req,
    output logic [BITS-1:0] imem_addr,
    input  logic [BITS-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [BITS-1:0] redirect_addr,
    input  logic            halt,
    output logic            instr_valid,
    output logic [BITS-1:0] instr,
    output logic [BITS-1:0] instr_pc,
    input  logic            instr_ready,
    output logic [CW-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW:0] W_DEPTH = (CW + 1)'(DEPTH);

    logic [BITS-1:0] r_pc;
    logic [BITS-1:0] r_inflight_pc;
    logic            r_inflight;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [BITS-1:0] r_instr [DEPTH];
    logic [BITS-1:0] r_ipc   [DEPTH];

    logic [CW:0] w_occ;
    logic        w_issue;
    logic        w_push;
    logic        w_pop;

    // Credit counts the outstanding read so a full queue can never be overrun.
    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = rst_ & ~halt & ~redirect & (w_occ < W_DEPTH);
    assign w_push  = r_inflight & ~redirect;
    assign w_pop   = instr_valid & instr_ready;

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = r_instr[r_rd];
    assign instr_pc    = r_ipc[r_rd];
    assign count       = r_count;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_pc          <= RESET_ADDR;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
        end else if (redirect) begin
            r_pc       <= redirect_addr;
            r_inflight <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + BITS'(1);
                r_inflight_pc <= r_pc;
            end
            r_inflight <= w_issue;
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr] <= imem_rdata;
            r_ipc[r_wr]   <= r_inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of the fetch stage.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        imem_req, redirect, halt, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_addr, instr, instr_pc;
    logic [2:0]  count;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc;
    logic [2:0]  w_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc, m_ipc;
    bit          m_infl;
    bit          m_iss;
    logic        l_req;
    logic [31:0] l_addr, l_waddr;

    always #5 clk = ~clk;

    fetch_queue u_dut (
        .clk(clk), .rst_(rst_), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_addr(redirect_addr),
        .halt(halt), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .count(count)
    );

    fetch_queue #(.RESET_ADDR(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst_(rst_), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect(1'b0), .redirect_addr(32'h0),
        .halt(1'b0), .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
        .instr_ready(1'b1), .count(w_count)
    );

    function automatic logic [31:0] memf(logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the queue holds exactly the words decode has yet to see.
    always @(negedge clk) begin
        if (!rst_) begin
            q.delete();
            m_pc   = 32'h0;
            m_ipc  = 32'h0;
            m_infl = 1'b0;
        end
        m_iss = rst_ && !halt && !redirect && (q.size() + int'(m_infl) < DEPTH);
        chk("imem_req", imem_req, m_iss);
        chk("imem_addr", imem_addr, m_pc);
        chk("count", count, q.size());
        chk("instr_valid", instr_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("instr", instr, q[0].i);
            chk("instr_pc", instr_pc, q[0].p);
        end
        if (rst_) begin
            if (redirect) begin
                q.delete();
                m_infl = 1'b0;
                m_pc   = redirect_addr;
            end else begin
                if (q.size() != 0 && instr_ready)
                    void'(q.pop_front());
                if (m_infl)
                    q.push_back('{i: memf(m_ipc), p: m_ipc});
                if (m_iss) begin
                    m_ipc = m_pc;
                    m_pc  = m_pc + 32'h1;
                end
                m_infl = m_iss;
            end
        end
    end

    always @(negedge clk) begin
        l_req   = imem_req;
        l_addr  = imem_addr;
        l_waddr = w_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        imem_rdata = l_req ? memf(l_addr) : $urandom;
        w_rdata    = memf(l_waddr);
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_     = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        look();
        chk("rst_count", count, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        tick();
        rst_ = 1'b1;
    endtask

    initial begin
        bit found;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        halt          = 1'b0;
        instr_ready   = 1'b1;
        imem_rdata    = 32'h0;
        w_rdata       = 32'h0;

        // Streaming from reset, plus the wrapping instance.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            look();
            chk("stream_addr", imem_addr, 32'(k));
            chk("stream_req", imem_req, 1);
            if (k >= 2) begin
                chk("stream_valid", instr_valid, 1);
                chk("stream_pc", instr_pc, 32'(k - 2));
                chk("stream_instr", instr, 32'h1000 + 32'(k - 2));
            end
            if (k < 4)
                chk("wrap_addr", w_addr, 32'hFFFF_FFFE + 32'(k));
            if (k >= 2) begin
                chk("wrap_valid", w_valid, 1);
                chk("wrap_pc", w_pc, 32'hFFFF_FFFE + 32'(k - 2));
            end
            tick();
        end

        // Fill with decode stalled, then drain.
        instr_ready = 1'b0;
        do_reset();
        repeat (8) begin
            look();
            tick();
        end
        look();
        chk("full_count", count, 4);
        chk("full_req", imem_req, 0);
        chk("full_pc", instr_pc, 0);
        tick();
        instr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            look();
            chk("drain_pc", instr_pc, 32'(j));
            if (j == 1) begin
                chk("resume_req", imem_req, 1);
                chk("resume_addr", imem_addr, 4);
            end
            tick();
        end

        // Redirect with three queued and one in flight.
        instr_ready = 1'b0;
        do_reset();
        repeat (4) begin
            look();
            tick();
        end
        redirect      = 1'b1;
        redirect_addr = 32'h40;
        look();
        chk("pre_redir_count", count, 3);
        tick();
        redirect = 1'b0;
        look();
        chk("redir_count", count, 0);
        chk("redir_valid", instr_valid, 0);
        chk("redir_addr", imem_addr, 32'h40);
        tick();
        look();
        chk("redir_valid2", instr_valid, 0);
        tick();
        look();
        chk("redir_valid3", instr_valid, 1);
        chk("redir_pc", instr_pc, 32'h40);
        chk("redir_instr", instr, 32'h1040);
        tick();

        // Halt at PC 8, redirect while halted, release.
        instr_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_addr == 32'h8)
                found = 1'b1;
            else
                tick();
        end
        chk("halt_reach_pc8", found, 1);
        halt = 1'b1;
        look();
        chk("halt_req", imem_req, 0);
        chk("halt_head", instr_pc, 6);
        tick();
        look();
        chk("halt_last_valid", instr_valid, 1);
        chk("halt_last_pc", instr_pc, 7);
        chk("halt_req2", imem_req, 0);
        tick();
        look();
        chk("halt_empty", instr_valid, 0);
        tick();
        redirect      = 1'b1;
        redirect_addr = 32'h20;
        look();
        chk("halt_redir_req", imem_req, 0);
        tick();
        redirect = 1'b0;
        look();
        chk("halt_hold_req", imem_req, 0);
        chk("halt_hold_addr", imem_addr, 32'h20);
        tick();
        halt = 1'b0;
        look();
        chk("unhalt_req", imem_req, 1);
        chk("unhalt_addr", imem_addr, 32'h20);
        tick();

        // Asynchronous reset with count=2 and a read in flight.
        instr_ready = 1'b0;
        do_reset();
        repeat (3) begin
            look();
            tick();
        end
        chk("pre_rst_count", count, 2);
        rst_ = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_count", count, 0);
        tick();
        rst_        = 1'b1;
        instr_ready = 1'b1;
        look();
        chk("restart_addr", imem_addr, 0);
        tick();
        look();
        tick();
        look();
        chk("restart_pc", instr_pc, 0);
        chk("restart_instr", instr, 32'h1000);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_          = ($urandom_range(399) != 0);
            redirect      = ($urandom_range(15) == 0);
            redirect_addr = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(3)) : $urandom;
            if ($urandom_range(9) == 0)
                halt = ~halt;
            instr_ready   = ($urandom_range(9) < 7);
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
